// File: rtl/qu_reorder_buffer.sv
// Qu reorder buffer: circular, in-order alloc/commit, out-of-order wb.
// Ports: alloc, exec, wb, commit handshakes; rd lookup; count/empty/full.
package qu_rob_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_RETIRED = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_PENDING = 2'b11
  } rob_state_e;
endpackage

import qu_rob_pkg::*;

module qu_reorder_buffer #(
  parameter int DEPTH       = 8,
  parameter int VALUE_WIDTH = 32,
  parameter int DEST_WIDTH  = 7,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   alloc_valid,
  input  logic [DEST_WIDTH-1:0]  alloc_dest,
  output logic                   alloc_ready,
  output logic [ADDR_WIDTH-1:0]  alloc_addr,
  input  logic                   exec_valid,
  input  logic [ADDR_WIDTH-1:0]  exec_addr,
  input  logic                   wb_valid,
  input  logic [ADDR_WIDTH-1:0]  wb_addr,
  input  logic [VALUE_WIDTH-1:0] wb_value,
  output logic                   commit_valid,
  input  logic                   commit_ready,
  output logic [ADDR_WIDTH-1:0]  commit_addr,
  output logic [DEST_WIDTH-1:0]  commit_dest,
  output logic [VALUE_WIDTH-1:0] commit_value,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [1:0]             rd_state,
  output logic [VALUE_WIDTH-1:0] rd_value,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   empty,
  output logic                   full
);

  rob_state_e             state_q [DEPTH];
  logic [VALUE_WIDTH-1:0] value_q [DEPTH];
  logic [DEST_WIDTH-1:0]  dest_q  [DEPTH];

  logic [ADDR_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] tail_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic alloc_fire;
  logic commit_fire;

  assign full        = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_addr  = tail_q;

  // Head state is registered, so commit_valid has no input path.
  assign commit_valid = (state_q[head_q] == ST_RETIRED);
  assign commit_addr  = head_q;
  assign commit_dest  = dest_q[head_q];
  assign commit_value = value_q[head_q];

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;

  assign rd_state = state_q[rd_addr];
  assign rd_value = value_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
        value_q[i] <= '0;
        dest_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Tail is EMPTY and head is RETIRED, so the branches
        // below never compete for one entry in a legal cycle.
        if (alloc_fire && tail_q == ADDR_WIDTH'(i)) begin
          state_q[i] <= ST_PENDING;
          dest_q[i]  <= alloc_dest;
          value_q[i] <= '0;
        end else if (commit_fire && head_q == ADDR_WIDTH'(i)) begin
          state_q[i] <= ST_EMPTY;
        end else if (wb_valid && wb_addr == ADDR_WIDTH'(i) &&
                     (state_q[i] == ST_PENDING ||
                      state_q[i] == ST_EXECUTE)) begin
          state_q[i] <= ST_RETIRED;
          value_q[i] <= wb_value;
        end else if (exec_valid && exec_addr == ADDR_WIDTH'(i) &&
                     state_q[i] == ST_PENDING) begin
          state_q[i] <= ST_EXECUTE;
        end
      end
      if (alloc_fire) begin
        tail_q <= tail_q + ADDR_WIDTH'(1);
      end
      if (commit_fire) begin
        head_q <= head_q + ADDR_WIDTH'(1);
      end
      unique case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_qu_reorder_buffer.sv
// Directed bench for qu_reorder_buffer (DEPTH=8).
// Steps drive at posedge+1 and check outputs before the next edge.
module tb_qu_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic [6:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_addr;
  logic        exec_valid;
  logic [2:0]  exec_addr;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_value;
  logic        commit_valid;
  logic        commit_ready;
  logic [2:0]  commit_addr;
  logic [6:0]  commit_dest;
  logic [31:0] commit_value;
  logic [2:0]  rd_addr;
  logic [1:0]  rd_state;
  logic [31:0] rd_value;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int total;
  int bad;

  qu_reorder_buffer #(
    .DEPTH(8), .VALUE_WIDTH(32), .DEST_WIDTH(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .exec_valid(exec_valid), .exec_addr(exec_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_addr(commit_addr), .commit_dest(commit_dest),
    .commit_value(commit_value),
    .rd_addr(rd_addr), .rd_state(rd_state), .rd_value(rd_value),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    alloc_valid  = 1'b0;
    exec_valid   = 1'b0;
    wb_valid     = 1'b0;
    commit_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    alloc_dest = '0;
    exec_addr  = '0;
    wb_addr    = '0;
    wb_value   = '0;
    rd_addr    = '0;
    #12;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_addr", 64'(alloc_addr), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_dest", 64'(commit_dest), 64'd0);
    chk("rst_commit_value", 64'(commit_value), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_state", 64'(rd_state), 64'd0);
    chk("rst_rd_value", 64'(rd_value), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill: 8 allocs, dests 10..17
    for (int i = 0; i < 8; i++) begin
      chk("fill_alloc_addr", 64'(alloc_addr), 64'(i));
      alloc_valid = 1'b1;
      alloc_dest  = 7'(10 + i);
      tick();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_ready", 64'(alloc_ready), 64'd0);
    alloc_dest = 7'd99;
    tick();
    alloc_valid = 1'b0;
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_tail", 64'(alloc_addr), 64'd0);
    rd_addr = 3'd5;
    #1;
    chk("fill_rd_state5", 64'(rd_state), 64'b11);
    chk("fill_head_dest", 64'(commit_dest), 64'd10);

    // Full with RETIRED head: commit wins, no alloc
    wb_valid = 1'b1;
    wb_addr  = 3'd0;
    wb_value = 32'h77;
    tick();
    wb_valid = 1'b0;
    chk("fh_commit_valid", 64'(commit_valid), 64'd1);
    chk("fh_commit_value", 64'(commit_value), 64'h77);
    alloc_valid  = 1'b1;
    alloc_dest   = 7'd50;
    commit_ready = 1'b1;
    tick();
    idle();
    chk("fh_count", 64'(count), 64'd7);
    chk("fh_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("fh_alloc_addr", 64'(alloc_addr), 64'd0);
    chk("fh_commit_addr", 64'(commit_addr), 64'd1);
    chk("fh_commit_valid2", 64'(commit_valid), 64'd0);
    rd_addr = 3'd0;
    #1;
    chk("fh_rd_state0", 64'(rd_state), 64'b00);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    tick();
    idle();
    chk("fl1_empty", 64'(empty), 64'd1);
    chk("fl1_count", 64'(count), 64'd0);
    chk("fl1_alloc_addr", 64'(alloc_addr), 64'd0);

    // In-order commit with out-of-order writeback
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 7'(20 + i);
      tick();
    end
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 3'd2;
    wb_value = 32'hC;
    tick();
    chk("ooo_cv_wb2", 64'(commit_valid), 64'd0);
    wb_addr      = 3'd0;
    wb_value     = 32'hA;
    commit_ready = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("ooo_cv0", 64'(commit_valid), 64'd1);
    chk("ooo_addr0", 64'(commit_addr), 64'd0);
    chk("ooo_dest0", 64'(commit_dest), 64'd20);
    chk("ooo_val0", 64'(commit_value), 64'hA);
    tick();
    chk("ooo_cv_wait", 64'(commit_valid), 64'd0);
    chk("ooo_addr_wait", 64'(commit_addr), 64'd1);
    chk("ooo_count_wait", 64'(count), 64'd2);
    tick();
    chk("ooo_cv_wait2", 64'(commit_valid), 64'd0);
    wb_valid = 1'b1;
    wb_addr  = 3'd1;
    wb_value = 32'hB;
    tick();
    wb_valid = 1'b0;
    chk("ooo_cv1", 64'(commit_valid), 64'd1);
    chk("ooo_dest1", 64'(commit_dest), 64'd21);
    chk("ooo_val1", 64'(commit_value), 64'hB);
    tick();
    chk("ooo_cv2", 64'(commit_valid), 64'd1);
    chk("ooo_addr2", 64'(commit_addr), 64'd2);
    chk("ooo_dest2", 64'(commit_dest), 64'd22);
    chk("ooo_val2", 64'(commit_value), 64'hC);
    tick();
    idle();
    chk("ooo_empty", 64'(empty), 64'd1);
    chk("ooo_cv_end", 64'(commit_valid), 64'd0);

    // Same-cycle exec+wb on entry 3, exec-only on entry 4
    chk("xw_alloc_addr", 64'(alloc_addr), 64'd3);
    alloc_valid = 1'b1;
    alloc_dest  = 7'd33;
    tick();
    rd_addr = 3'd3;
    #1;
    chk("xw_pending", 64'(rd_state), 64'b11);
    alloc_dest = 7'd34;
    exec_valid = 1'b1;
    exec_addr  = 3'd3;
    wb_valid   = 1'b1;
    wb_addr    = 3'd3;
    wb_value   = 32'h55;
    tick();
    idle();
    chk("xw_state", 64'(rd_state), 64'b01);
    chk("xw_value", 64'(rd_value), 64'h55);
    exec_valid = 1'b1;
    exec_addr  = 3'd4;
    tick();
    idle();
    rd_addr = 3'd4;
    #1;
    chk("x4_state", 64'(rd_state), 64'b10);
    commit_ready = 1'b1;
    tick();
    idle();
    chk("x4_no_commit", 64'(commit_valid), 64'd0);
    wb_valid = 1'b1;
    wb_addr  = 3'd3;
    wb_value = 32'h99;
    tick();
    idle();
    rd_addr = 3'd3;
    #1;
    chk("xw_ign_state", 64'(rd_state), 64'b00);
    chk("xw_count", 64'(count), 64'd1);
    flush = 1'b1;
    tick();
    idle();

    // Wrap: 20 alloc/wb/commit rounds
    for (int i = 0; i < 20; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 7'(40 + i);
      tick();
      alloc_valid = 1'b0;
      wb_valid = 1'b1;
      wb_addr  = 3'(i % 8);
      wb_value = 32'(32'h100 + i);
      tick();
      wb_valid = 1'b0;
      chk("wr_cv", 64'(commit_valid), 64'd1);
      chk("wr_addr", 64'(commit_addr), 64'(i % 8));
      chk("wr_dest", 64'(commit_dest), 64'(40 + i));
      chk("wr_val", 64'(commit_value), 64'(32'h100 + i));
      commit_ready = 1'b1;
      tick();
      commit_ready = 1'b0;
      chk("wr_count", 64'(count), 64'd0);
    end

    // Flush racing alloc, wb and commit
    alloc_valid = 1'b1;
    alloc_dest  = 7'd60;
    tick();
    alloc_dest = 7'd61;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 3'd4;
    wb_value = 32'h1;
    tick();
    chk("fl2_pre_cv", 64'(commit_valid), 64'd1);
    flush        = 1'b1;
    alloc_valid  = 1'b1;
    wb_addr      = 3'd5;
    commit_ready = 1'b1;
    tick();
    idle();
    chk("fl2_empty", 64'(empty), 64'd1);
    chk("fl2_count", 64'(count), 64'd0);
    chk("fl2_cv", 64'(commit_valid), 64'd0);
    chk("fl2_alloc_addr", 64'(alloc_addr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("fl2_rd_state", 64'(rd_state), 64'b00);
    end

    // Async reset mid-stream
    tick();
    alloc_valid = 1'b1;
    alloc_dest  = 7'd70;
    tick();
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 3'd0;
    wb_value = 32'h5;
    tick();
    wb_valid = 1'b0;
    chk("ar_pre_count", 64'(count), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_empty", 64'(empty), 64'd1);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_cv", 64'(commit_valid), 64'd0);
    chk("ar_alloc_addr", 64'(alloc_addr), 64'd0);
    rd_addr = 3'd1;
    #1;
    chk("ar_rd_state", 64'(rd_state), 64'b00);
    chk("ar_rd_value", 64'(rd_value), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qu_reorder_buffer.md
Name: qu_reorder_buffer

Overview:
Parametrised circular reorder buffer for the Qu out-of-order core, generalising the fixed 8-entry ROB cell format to arbitrary depth and value/destination widths. It allocates entries in program order at dispatch, tracks each entry through PENDING, EXECUTE and RETIRED, and accepts out-of-order writebacks. It commits one entry per cycle in order to the physical register file and supports a single-cycle full flush for mispredict recovery.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
VALUE_WIDTH, 32, width of the result value field
DEST_WIDTH, 7, physical register address width (PHY_RF_ADDR_WIDTH)
ADDR_WIDTH, $clog2(DEPTH), entry index width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries this cycle
alloc_valid  in  1  dispatch requests an entry
alloc_dest  in  DEST_WIDTH  destination physical register
alloc_ready  out  1  entry available (not full)
alloc_addr  out  ADDR_WIDTH  index given to the allocation (= tail)
exec_valid  in  1  issue notification
exec_addr  in  ADDR_WIDTH  entry entering execution
wb_valid  in  1  result writeback
wb_addr  in  ADDR_WIDTH  entry written back
wb_value  in  VALUE_WIDTH  result value
commit_valid  out  1  head entry is RETIRED
commit_ready  in  1  consumer accepts the commit
commit_addr  out  ADDR_WIDTH  head index
commit_dest  out  DEST_WIDTH  head destination
commit_value  out  VALUE_WIDTH  head value
rd_addr  in  ADDR_WIDTH  operand lookup index
rd_state  out  2  state of rd_addr (combinational)
rd_value  out  VALUE_WIDTH  value of rd_addr (combinational)
count  out  ADDR_WIDTH+1  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Entry states use the package encoding: EMPTY=00, RETIRED=01 (result valid), EXECUTE=10, PENDING=11.
- Reset (async, rst_n low): head=tail=0, count=0, all states EMPTY, values and dests 0. Outputs: alloc_ready=1, alloc_addr=0, commit_valid=0, commit_addr/dest/value=0, empty=1, full=0, rd_state=00, rd_value=0. Reset asserted mid-operation discards everything immediately.
- Allocation: fires on alloc_valid && alloc_ready. Entry[tail] gets state PENDING, dest=alloc_dest, value=0. tail increments modulo DEPTH. alloc_ready = !full. It does not consider a same-cycle commit, so a full buffer never allocates.
- Exec: exec_valid on a PENDING entry sets it to EXECUTE next cycle. On any other state the request is ignored.
- Writeback: wb_valid on a PENDING or EXECUTE entry stores wb_value and sets RETIRED next cycle. Writebacks to EMPTY or RETIRED entries are ignored. Same-cycle exec and wb to the same entry: wb wins and the entry becomes RETIRED.
- Commit:
  - commit_valid = (state[head] == RETIRED). It is driven only from registers, with no input-to-output combinational path.
  - commit_addr/dest/value always reflect the head entry.
  - On commit_valid && commit_ready, entry[head] becomes EMPTY and head increments modulo DEPTH.
  - Commit is in order, at most one per cycle.
- Simultaneous alloc and commit: count is unchanged and both pointers advance. With DEPTH=1 occupancy this is legal only when the buffer is not full.
- Count: count += alloc_fire, count -= commit_fire. Wrap-around of head and tail past DEPTH-1 returns them to 0.
- Flush: has priority over alloc, exec, wb and commit in the same cycle. Next cycle all states are EMPTY, head=tail=0 and count=0. Values and dests may keep stale data.
- Lookup: rd_state/rd_value are a combinational read of the current registered entry. They do not show same-cycle writebacks; the consumer must snoop wb separately.
- Latency: an allocated entry is visible to lookup one cycle later. A written-back entry can commit, at the earliest, the cycle after wb.

Test Plan:
- Reset then 8 allocs (dests 10..17) with DEPTH=8 -> alloc_addr 0..7, full=1, count=8, alloc_ready=0; a 9th alloc_valid is dropped and tail stays 0.
- Alloc entries 0,1,2; wb entry 2 with 0xC, then entry 0 with 0xA, commit_ready=1 -> commits entry 0 (dest, 0xA) only; commit_valid stays 0 until entry 1 is written back with 0xB, then entries 1 and 2 commit on consecutive cycles.
- exec_addr=3 and wb_addr=3 (value 0x55) in the same cycle on a PENDING entry -> next cycle rd_addr=3 returns state 01, value 0x55; a later wb to the now-EMPTY entry 3 is ignored.
- Full buffer with head RETIRED, alloc_valid and commit_ready both high -> commit occurs, no alloc; next cycle alloc_ready=1, count=7.
- Wrap test: stream 20 alloc/wb/commit sequences -> commit_addr sequence 0..7,0..7,0..3 with matching dests, and count never exceeds 8.
- flush asserted together with alloc, wb and commit -> next cycle empty=1, count=0, commit_valid=0, alloc_addr=0, all rd_state=00. An async rst_n pulse mid-stream gives the same result immediately.
